vga_write_arbiter: RTL and testbench



---
 rtl/vga_write_arbiter.sv | 141 ++++++++++++++
 tb/tb_vga_write_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_write_arbiter.sv
// Merges the player-sprite and obstacle pixel streams into one VGA adapter write port.
// Each source has its own FIFO. At most one pixel is popped per clock and sent out on registered outputs.
module vga_write_arbiter #(
  parameter int unsigned nX             = 10,
  parameter int unsigned nY             = 9,
  parameter int unsigned COLOR_DEPTH    = 9,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned FIFO_AW        = 4,
  parameter int unsigned FIXED_PRIORITY = 0
) (
  input  logic                   Resetn,
  input  logic                   Clock,
  input  logic [nX-1:0]          p_x,
  input  logic [nY-1:0]          p_y,
  input  logic [COLOR_DEPTH-1:0] p_color,
  input  logic                   p_write,
  output logic                   p_ready,
  input  logic [nX-1:0]          o_x,
  input  logic [nY-1:0]          o_y,
  input  logic [COLOR_DEPTH-1:0] o_color,
  input  logic                   o_write,
  output logic                   o_ready,
  output logic [nX-1:0]          VGA_x,
  output logic [nY-1:0]          VGA_y,
  output logic [COLOR_DEPTH-1:0] VGA_color,
  output logic                   VGA_write,
  input  logic                   clear_overflow,
  output logic [1:0]             overflow
);

  localparam int unsigned W = nX + nY + COLOR_DEPTH;
  localparam logic [FIFO_AW:0] FULL_CNT  = (FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW:0] READY_MAX = (FIFO_AW+1)'(FIFO_DEPTH - 3);

  typedef enum logic {SRC0 = 1'b0, SRC1 = 1'b1} src_e;

  logic [W-1:0]           wdata [2];
  logic [1:0]             wr;
  logic [W-1:0]           mem_q [2][FIFO_DEPTH];
  logic [FIFO_AW-1:0]     wptr_q [2];
  logic [FIFO_AW-1:0]     wptr_d [2];
  logic [FIFO_AW-1:0]     rptr_q [2];
  logic [FIFO_AW-1:0]     rptr_d [2];
  logic [FIFO_AW:0]       cnt_q  [2];
  logic [FIFO_AW:0]       cnt_d  [2];
  logic [1:0]             nonempty, pop, push, drop;
  logic [1:0]             overflow_q, overflow_d;
  src_e                   last_q, last_d;
  logic [W-1:0]           head;
  logic [nX-1:0]          vga_x_q, vga_x_d;
  logic [nY-1:0]          vga_y_q, vga_y_d;
  logic [COLOR_DEPTH-1:0] vga_color_q, vga_color_d;
  logic                   vga_write_q, vga_write_d;

  assign wdata[0] = {p_x, p_y, p_color};
  assign wdata[1] = {o_x, o_y, o_color};
  assign wr       = {o_write, p_write};

  // Grant decision uses only the pre-edge counts, so it never depends on this cycle's pushes.
  always_comb begin
    pop    = '0;
    last_d = last_q;
    for (int unsigned i = 0; i < 2; i++) nonempty[i] = (cnt_q[i] != '0);
    if (nonempty == 2'b11) begin
      if (FIXED_PRIORITY != 0 || last_q == SRC1) pop = 2'b01;
      else                                       pop = 2'b10;
    end else begin
      pop = nonempty;
    end
    if (pop[0])      last_d = SRC0;
    else if (pop[1]) last_d = SRC1;
    head = pop[1] ? mem_q[1][rptr_q[1]] : mem_q[0][rptr_q[0]];
  end

  // A full FIFO still accepts a push when its head is being popped on the same edge.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      push[i]   = wr[i] && ((cnt_q[i] != FULL_CNT) || pop[i]);
      drop[i]   = wr[i] && !push[i];
      wptr_d[i] = wptr_q[i] + FIFO_AW'(push[i]);
      rptr_d[i] = rptr_q[i] + FIFO_AW'(pop[i]);
      cnt_d[i]  = cnt_q[i] + (FIFO_AW+1)'(push[i]) - (FIFO_AW+1)'(pop[i]);
    end
    overflow_d = (clear_overflow ? 2'b00 : overflow_q) | drop;
  end

  always_comb begin
    vga_x_d     = vga_x_q;
    vga_y_d     = vga_y_q;
    vga_color_d = vga_color_q;
    vga_write_d = |pop;
    if (|pop) begin
      vga_x_d     = head[W-1 -: nX];
      vga_y_d     = head[nY+COLOR_DEPTH-1 -: nY];
      vga_color_d = head[COLOR_DEPTH-1:0];
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int unsigned i = 0; i < 2; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      overflow_q  <= '0;
      last_q      <= SRC1;
      vga_x_q     <= '0;
      vga_y_q     <= '0;
      vga_color_q <= '0;
      vga_write_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      overflow_q  <= overflow_d;
      last_q      <= last_d;
      vga_x_q     <= vga_x_d;
      vga_y_q     <= vga_y_d;
      vga_color_q <= vga_color_d;
      vga_write_q <= vga_write_d;
    end
  end

  always_ff @(posedge Clock) begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (push[i]) mem_q[i][wptr_q[i]] <= wdata[i];
    end
  end

  assign p_ready   = (cnt_q[0] <= READY_MAX);
  assign o_ready   = (cnt_q[1] <= READY_MAX);
  assign VGA_x     = vga_x_q;
  assign VGA_y     = vga_y_q;
  assign VGA_color = vga_color_q;
  assign VGA_write = vga_write_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed bench: round-robin and fixed-priority instances share the same stimulus.
// It covers ordering, overflow, asynchronous reset and pointer wrap.
module tb_vga_write_arbiter;

  logic       Resetn, Clock;
  logic [9:0] p_x, o_x;
  logic [8:0] p_y, o_y, p_color, o_color;
  logic       p_write, o_write, clear_overflow;
  logic       p_ready, o_ready, VGA_write;
  logic [9:0] VGA_x;
  logic [8:0] VGA_y, VGA_color;
  logic [1:0] overflow;
  logic       f_p_ready, f_o_ready, f_VGA_write;
  logic [9:0] f_VGA_x;
  logic [8:0] f_VGA_y, f_VGA_color;
  logic [1:0] f_overflow;

  int tests = 0;
  int fails = 0;

  vga_write_arbiter #(.FIXED_PRIORITY(0)) dut (
    .Resetn(Resetn), .Clock(Clock),
    .p_x(p_x), .p_y(p_y), .p_color(p_color), .p_write(p_write), .p_ready(p_ready),
    .o_x(o_x), .o_y(o_y), .o_color(o_color), .o_write(o_write), .o_ready(o_ready),
    .VGA_x(VGA_x), .VGA_y(VGA_y), .VGA_color(VGA_color), .VGA_write(VGA_write),
    .clear_overflow(clear_overflow), .overflow(overflow));

  vga_write_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
    .Resetn(Resetn), .Clock(Clock),
    .p_x(p_x), .p_y(p_y), .p_color(p_color), .p_write(p_write), .p_ready(f_p_ready),
    .o_x(o_x), .o_y(o_y), .o_color(o_color), .o_write(o_write), .o_ready(f_o_ready),
    .VGA_x(f_VGA_x), .VGA_y(f_VGA_y), .VGA_color(f_VGA_color), .VGA_write(f_VGA_write),
    .clear_overflow(clear_overflow), .overflow(f_overflow));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic       pw;
    logic [9:0] px;
    logic [8:0] py, pc;
    logic       ow;
    logic [9:0] ox;
    logic       e_vw;
    logic [9:0] e_x;
    logic [8:0] e_y, e_c;
    logic [9:0] e_fx;
  } vec_t;

  vec_t vecs[$];

  task automatic add_row(input logic pw, input int px, input int py, input int pc,
                         input logic ow, input int ox, input logic e_vw,
                         input int e_x, input int e_y, input int e_c, input int e_fx);
    vec_t v;
    v.pw = pw; v.px = 10'(px); v.py = 9'(py); v.pc = 9'(pc);
    v.ow = ow; v.ox = 10'(ox);
    v.e_vw = e_vw; v.e_x = 10'(e_x); v.e_y = 9'(e_y); v.e_c = 9'(e_c); v.e_fx = 10'(e_fx);
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    p_write = 1'b0; o_write = 1'b0; clear_overflow = 1'b0;
    p_x = '0; p_y = '0; p_color = '0; o_x = '0; o_y = '0; o_color = '0;
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    #2 Resetn = 1'b0;
    #3 Resetn = 1'b1;
    step();
  endtask

  int pq[$];
  int oq[$];
  int exp_pq[$];
  int exp_oq[$];
  int errs;
  int nout;

  initial begin
    Resetn = 1'b0;
    idle_inputs();
    #12;
    chk("reset_vga_write", VGA_write, 0);
    chk("reset_vga_x", VGA_x, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_ready", {p_ready, o_ready}, 2'b11);
    Resetn = 1'b1;
    step();

    // Round-robin vs fixed priority tie, then a single player pixel.
    //      pw px  py  pc     ow ox   vw  x    y    c    fx
    add_row(1, 0,  0,  0,     1, 200, 0,  0,   0,   0,   0);
    add_row(1, 1,  1,  1,     1, 201, 1,  0,   0,   0,   0);
    add_row(1, 2,  2,  2,     1, 202, 1,  200, 200, 200, 1);
    add_row(1, 3,  3,  3,     1, 203, 1,  1,   1,   1,   2);
    add_row(0, 0,  0,  0,     0, 0,   1,  201, 201, 201, 3);
    add_row(0, 0,  0,  0,     0, 0,   1,  2,   2,   2,   200);
    add_row(0, 0,  0,  0,     0, 0,   1,  202, 202, 202, 201);
    add_row(0, 0,  0,  0,     0, 0,   1,  3,   3,   3,   202);
    add_row(0, 0,  0,  0,     0, 0,   1,  203, 203, 203, 203);
    add_row(0, 0,  0,  0,     0, 0,   0,  203, 203, 203, 203);
    add_row(1, 100, 360, 'h1FF, 0, 0, 0,  203, 203, 203, 203);
    add_row(0, 0,  0,  0,     0, 0,   1,  100, 360, 'h1FF, 100);
    add_row(0, 0,  0,  0,     0, 0,   0,  100, 360, 'h1FF, 100);

    foreach (vecs[i]) begin
      p_write = vecs[i].pw; p_x = vecs[i].px; p_y = vecs[i].py; p_color = vecs[i].pc;
      o_write = vecs[i].ow; o_x = vecs[i].ox; o_y = 9'(vecs[i].ox); o_color = 9'(vecs[i].ox);
      step();
      chk($sformatf("row%0d_vga_write", i), VGA_write, vecs[i].e_vw);
      chk($sformatf("row%0d_vga_x", i), VGA_x, vecs[i].e_x);
      chk($sformatf("row%0d_vga_y", i), VGA_y, vecs[i].e_y);
      chk($sformatf("row%0d_vga_color", i), VGA_color, vecs[i].e_c);
      chk($sformatf("row%0d_fp_write", i), f_VGA_write, vecs[i].e_vw);
      chk($sformatf("row%0d_fp_x", i), f_VGA_x, vecs[i].e_fx);
      chk($sformatf("row%0d_overflow", i), overflow, 0);
      chk($sformatf("row%0d_ready", i), {p_ready, o_ready}, 2'b11);
    end
    idle_inputs();

    // Overflow: both sources write every cycle. Edges 0..30 fill both FIFOs to 16,
    // then on edges 31..70 player pushes survive only on player-pop (odd) edges.
    do_reset();
    for (int k = 0; k <= 70; k++) begin
      if (k <= 30 || (k % 2) == 1) exp_pq.push_back(k);
      if (k <= 30 || (k % 2) == 0) exp_oq.push_back(k);
    end
    for (int k = 0; k <= 70; k++) begin
      p_write = 1'b1; p_x = 10'(k); p_y = 9'(k); p_color = 9'd1;
      o_write = 1'b1; o_x = 10'(k); o_y = 9'(k); o_color = 9'd2;
      step();
      if (VGA_write) begin
        if (VGA_color == 9'd1) pq.push_back(int'(VGA_x));
        else                   oq.push_back(int'(VGA_x));
      end
      if (k == 24) chk("p_ready_cnt13", p_ready, 1);
      if (k == 25) chk("p_ready_cnt13b", p_ready, 1);
      if (k == 26) chk("p_ready_cnt14", p_ready, 0);
      if (k == 30) chk("ovf_none_at_full", overflow, 2'b00);
      if (k == 30) chk("o_ready_full", o_ready, 0);
      if (k == 31) chk("ovf_obstacle_drop", overflow, 2'b10);
      if (k == 32) chk("ovf_both_drop", overflow, 2'b11);
    end
    idle_inputs();
    for (int k = 0; k < 40; k++) begin
      step();
      if (VGA_write) begin
        if (VGA_color == 9'd1) pq.push_back(int'(VGA_x));
        else                   oq.push_back(int'(VGA_x));
      end
    end
    chk("player_out_count", pq.size(), 51);
    chk("obstacle_out_count", oq.size(), 51);
    errs = 0;
    for (int i = 0; i < 51; i++) begin
      if (i >= pq.size() || pq[i] != exp_pq[i]) errs++;
      if (i >= oq.size() || oq[i] != exp_oq[i]) errs++;
    end
    chk("overflow_order_errors", errs, 0);
    chk("ovf_sticky", overflow, 2'b11);
    chk("ready_after_drain", {p_ready, o_ready}, 2'b11);
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    chk("ovf_cleared", overflow, 2'b00);

    // Asynchronous reset with both FIFOs full and output streaming.
    for (int k = 0; k <= 31; k++) begin
      p_write = 1'b1; p_x = 10'(k); p_color = 9'd1;
      o_write = 1'b1; o_x = 10'(k); o_color = 9'd2;
      step();
    end
    idle_inputs();
    chk("pre_async_write", VGA_write, 1);
    chk("pre_async_ready", {p_ready, o_ready}, 2'b00);
    chk("pre_async_ovf", overflow, 2'b10);
    #2 Resetn = 1'b0;
    #1;
    chk("async_vga_write", VGA_write, 0);
    chk("async_vga_x", VGA_x, 0);
    chk("async_overflow", overflow, 2'b00);
    chk("async_ready", {p_ready, o_ready}, 2'b11);
    #1 Resetn = 1'b1;
    nout = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (VGA_write) nout++;
    end
    chk("no_stale_after_reset", nout, 0);

    // Pointer wrap: 100 obstacle pixels back to back.
    errs = 0;
    nout = 0;
    for (int k = 0; k <= 100; k++) begin
      o_write = (k < 100); o_x = 10'(k + 300); o_y = 9'(k); o_color = 9'(k);
      step();
      if (k >= 1) begin
        if (VGA_write) nout++;
        if (!VGA_write || VGA_color != 9'(k - 1) || VGA_x != 10'(k + 299)) errs++;
      end else if (VGA_write) begin
        errs++;
      end
    end
    idle_inputs();
    step();
    chk("wrap_tail_idle", VGA_write, 0);
    chk("wrap_out_count", nout, 100);
    chk("wrap_errors", errs, 0);
    chk("wrap_overflow", overflow, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
